// File: rtl/shift_ll_pipelined_pkg.sv
// Shared ALU shifter definitions: widths and the per-stage pipeline record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_ll_pipelined_pkg;

    localparam int WIDTH   = 32;       // data width, equals 2**SHAMT_W
    localparam int SHAMT_W = 5;        // shift-amount width and stage count
    localparam int TAG_W   = 4;        // opaque tag width
    localparam int NSTAGE  = SHAMT_W;  // one stage per shift-amount bit
    localparam int CNT_W   = 3;        // occupancy counter, holds 0..NSTAGE

    // One pipeline slot: everything an operation needs as it walks the stages.
    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] amt;
        logic [TAG_W-1:0]   tag;
        logic               lost;
    } stage_t;

endpackage

// File: rtl/shift_ll_pipelined_if.sv
// Operation/result handshake bundle for the pipelined left shifter.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready flow control.
interface shift_ll_pipelined_if;
    import shift_ll_pipelined_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_operandA;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   shiftLL_result;
    logic [TAG_W-1:0]   out_tag;
    logic               out_lost;
    logic [CNT_W-1:0]   inflight_count;

    // Shifter side: consumes operations, produces results and occupancy.
    modport slave (
        input  in_valid, data_operandA, ctrl_shiftamt, in_tag, out_ready,
        output in_ready, out_valid, shiftLL_result, out_tag, out_lost, inflight_count
    );

    // Requester side: issues operations and sinks results.
    modport master (
        output in_valid, data_operandA, ctrl_shiftamt, in_tag, out_ready,
        input  in_ready, out_valid, shiftLL_result, out_tag, out_lost, inflight_count
    );

endinterface

// File: rtl/shift_ll_pipelined_stage.sv
// One barrel-shifter step: shift left by 2**K when amt[K] is set, track spilled ones.
// Latency: 0 cycles (purely combinational; the top registers the result).
// Backpressure: none here; the top holds the registers when the pipe stalls.
module shift_ll_stage
    import shift_ll_pipelined_pkg::*;
#(
    parameter int K = 0
) (
    input  stage_t stg_i,
    output stage_t stg_o
);

    localparam int SH = 1 << K;

    // Bits that fall off the top if this stage shifts.
    logic [SH-1:0] spill;
    assign spill = stg_i.data[WIDTH-1 -: SH];

    // Pass the record through, applying this stage's shift and loss update.
    always_comb begin
        stg_o = stg_i;
        if (stg_i.amt[K]) begin
            stg_o.data = stg_i.data << SH;
            stg_o.lost = stg_i.lost | (|spill);
        end
    end

endmodule

// File: rtl/shift_ll_pipelined.sv
// Five-stage pipelined logical-left shifter with tag, shifted-out flag and occupancy.
// Latency: 5 cycles from accept to out_valid; one operation per cycle sustained.
// Backpressure: global advance; whole pipe holds while out_valid && !out_ready.
module shift_ll_pipelined
    import shift_ll_pipelined_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    shift_ll_pipelined_if.slave  bus
);

    stage_t           in_rec;
    stage_t           stg_d [NSTAGE];
    stage_t           stg_q [NSTAGE];
    logic             adv;
    logic             accept;
    logic             emit;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Every stage moves together; a held result freezes the entire pipe.
    assign adv    = !stg_q[NSTAGE-1].valid | bus.out_ready;
    assign accept = bus.in_valid & adv;
    assign emit   = stg_q[NSTAGE-1].valid & bus.out_ready;

    // Operand fields are only taken on an accepted transfer; otherwise a zero bubble enters.
    always_comb begin
        in_rec = '0;
        if (accept) begin
            in_rec.valid = 1'b1;
            in_rec.data  = bus.data_operandA;
            in_rec.amt   = bus.ctrl_shiftamt;
            in_rec.tag   = bus.in_tag;
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_first
            shift_ll_stage #(.K(0)) u_stage (
                .stg_i (in_rec),
                .stg_o (stg_d[0])
            );
        end else begin : g_rest
            shift_ll_stage #(.K(k)) u_stage (
                .stg_i (stg_q[k-1]),
                .stg_o (stg_d[k])
            );
        end
    end

    // Occupancy: one in, one out per advance; both or neither leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(emit);
    end

    // Pipeline and occupancy registers; reset discards anything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                stg_q[k] <= '0;
            end
            cnt_q <= '0;
        end else if (adv) begin
            for (int k = 0; k < NSTAGE; k++) begin
                stg_q[k] <= stg_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready       = adv;
    assign bus.out_valid      = stg_q[NSTAGE-1].valid;
    assign bus.shiftLL_result = stg_q[NSTAGE-1].data;
    assign bus.out_tag        = stg_q[NSTAGE-1].tag;
    assign bus.out_lost       = stg_q[NSTAGE-1].lost;
    assign bus.inflight_count = cnt_q;

endmodule

// File: tb/tb_shift_ll_pipelined.sv
// Directed bench for the pipelined left shifter with a result scoreboard.
// Latency: checks the 5-cycle accept-to-result delay.
// Backpressure: stalls out_ready mid-stream and checks hold, order and drain.
module tb_shift_ll_pipelined;
    import shift_ll_pipelined_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        lost;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    shift_ll_pipelined_if bus();

    shift_ll_pipelined dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   n_chk   = 0;
    int   n_fail  = 0;
    int   max_infl = 0;
    int   n_stall = 0;
    int   n_emit  = 0;
    bit   mon_en  = 1'b0;
    exp_t sb [$];

    logic [31:0] strm_exp [8] = '{32'd1, 32'd4, 32'd12, 32'd32,
                                  32'd80, 32'd192, 32'd448, 32'd1024};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: widen to 64 bits so shifted-out bits land in the upper half.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [4:0] s);
        model = {32'd0, a} << s;
    endfunction

    // Scoreboard monitor, sampled on the falling edge away from the active edge.
    always @(negedge clock) begin
        exp_t        e;
        logic [63:0] m;
        if (!reset && mon_en) begin
            if (int'(bus.inflight_count) > max_infl) max_infl = int'(bus.inflight_count);
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    chk("sb_res",  bus.shiftLL_result, e.res);
                    chk("sb_tag",  32'(bus.out_tag),   32'(e.tag));
                    chk("sb_lost", 32'(bus.out_lost),  32'(e.lost));
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        n_emit++;
                    end
                end
                if (!bus.out_ready) begin
                    n_stall++;
                    chk("in_rdy_stall", 32'(bus.in_ready), 32'd0);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                m      = model(bus.data_operandA, bus.ctrl_shiftamt);
                e.res  = m[31:0];
                e.tag  = bus.in_tag;
                e.lost = |m[63:32];
                sb.push_back(e);
            end
        end
    end

    task automatic send_one(input string nm, input logic [31:0] a, input logic [4:0] s,
                            input logic [3:0] t, input logic [31:0] exp_res, input logic exp_lost);
        int lat;
        lat = 0;
        @(posedge clock); #1;
        bus.in_valid      = 1'b1;
        bus.data_operandA = a;
        bus.ctrl_shiftamt = s;
        bus.in_tag        = t;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        chk({nm, "_lat"},  32'(lat), 32'd5);
        chk({nm, "_res"},  bus.shiftLL_result, exp_res);
        chk({nm, "_tag"},  32'(bus.out_tag), 32'(t));
        chk({nm, "_lost"}, 32'(bus.out_lost), 32'(exp_lost));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit stale;
        int emit0;

        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.data_operandA = '0;
        bus.ctrl_shiftamt = '0;
        bus.in_tag        = '0;
        bus.out_ready     = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_inflight",  32'(bus.inflight_count), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_result",    bus.shiftLL_result, 32'd0);
        chk("rst_tag",       32'(bus.out_tag), 32'd0);
        chk("rst_lost",      32'(bus.out_lost), 32'd0);
        mon_en = 1'b1;

        // Single operations with hand-computed results
        send_one("a1s31",  32'h0000_0001, 5'd31, 4'd3, 32'h8000_0000, 1'b0);
        send_one("ones4",  32'hFFFF_FFFF, 5'd4,  4'd5, 32'hFFFF_FFF0, 1'b1);
        send_one("pass0",  32'h1234_5678, 5'd0,  4'd6, 32'h1234_5678, 1'b0);

        // Back-to-back stream of 8 operations
        max_infl = 0;
        @(posedge clock); #1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bus.in_valid      = 1'b1;
                    bus.data_operandA = 32'(i + 1);
                    bus.ctrl_shiftamt = 5'(i);
                    bus.in_tag        = 4'(i);
                    @(posedge clock); #1;
                end
                bus.in_valid = 1'b0;
            end
            begin
                found = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clock);
                    if (bus.out_valid) begin
                        found = 1'b1;
                        break;
                    end
                end
                chk("strm_start", 32'(found), 32'd1);
                for (int i = 0; i < 8; i++) begin
                    chk("strm_valid", 32'(bus.out_valid), 32'd1);
                    chk("strm_res",   bus.shiftLL_result, strm_exp[i]);
                    chk("strm_tag",   32'(bus.out_tag), 32'(i));
                    @(negedge clock);
                end
                chk("strm_end", 32'(bus.out_valid), 32'd0);
            end
        join
        chk("strm_peak", 32'(max_infl), 32'd5);

        // Backpressure: downstream stalls for 6 cycles while the source keeps pushing
        n_stall = 0;
        emit0   = n_emit;
        @(posedge clock); #1;
        fork
            begin
                bit acc;
                for (int k = 0; k < 10; k++) begin
                    bus.in_valid      = 1'b1;
                    bus.data_operandA = 32'hC000_0001 + 32'(k) * 32'h0000_0111;
                    bus.ctrl_shiftamt = 5'(k * 3);
                    bus.in_tag        = 4'(k);
                    acc = 1'b0;
                    for (int w = 0; w < 50 && !acc; w++) begin
                        @(negedge clock);
                        acc = bus.in_ready;
                        @(posedge clock); #1;
                    end
                    if (!acc) chk("bp_accept_timeout", 32'd0, 32'd1);
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clock);
                #1 bus.out_ready = 1'b0;
                repeat (6) @(posedge clock);
                #1 bus.out_ready = 1'b1;
            end
        join
        for (int w = 0; w < 50 && (sb.size() != 0); w++) @(negedge clock);
        chk("bp_stall_seen", 32'(n_stall > 0), 32'd1);
        chk("bp_drain",      32'(sb.size()), 32'd0);
        chk("bp_emit_cnt",   32'(n_emit - emit0), 32'd10);

        // Reset with three operations in flight
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid      = 1'b1;
            bus.data_operandA = 32'h0000_0010 << i;
            bus.ctrl_shiftamt = 5'd1;
            bus.in_tag        = 4'(i + 12);
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("rst_pre_infl", 32'(bus.inflight_count), 32'd3);
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_infl",  32'(bus.inflight_count), 32'd0);
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (bus.out_valid) stale = 1'b1;
        end
        chk("rst_no_stale", 32'(stale), 32'd0);

        // Top-bit boundary cases
        send_one("top1", 32'h4000_0000, 5'd1, 4'd9,  32'h8000_0000, 1'b0);
        send_one("top2", 32'h4000_0000, 5'd2, 4'd10, 32'h0000_0000, 1'b1);

        @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
